// File: rtl/stop_it_game.sv
// stop_it_game: controller for the "Stop It" reaction game.
//
// Captures a target from the upstream LFSR on go_i, shows it for TARGET_CYCLES, then runs a
// wrapping 0..31 counter stepping every P cycles. A stop_i press is judged against the target;
// running out of laps (MAX_LAPS wraps of 31->0) is an automatic loss. The result is held for
// RESULT_CYCLES before returning to idle. score_o tracks the consecutive-win streak.
//
// Optional build macro STOP_IT_SPEEDUP_EN: when defined, P = STEP_CYCLES >> min(score_o, 3),
// latched on entry to the counting phase. When undefined, P = STEP_CYCLES.
//
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   go_i      start request pulse
//   stop_i    stop request pulse
//   rand_i    random value from the LFSR
//   next_o    one-cycle pulse advancing the LFSR after an accepted start
//   target_o  captured target value
//   count_o   running counter value
//   state_o   0=idle, 1=show, 2=count, 3=result
//   win_o     high throughout result when the round was won
//   lose_o    high throughout result when the round was lost
//   score_o   consecutive-win streak, saturating at 255
module stop_it_game #(
  parameter int unsigned STEP_CYCLES   = 10000000,
  parameter int unsigned TARGET_CYCLES = 50000000,
  parameter int unsigned RESULT_CYCLES = 100000000,
  parameter int unsigned MAX_LAPS      = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       go_i,
  input  logic       stop_i,
  input  logic [4:0] rand_i,
  output logic       next_o,
  output logic [4:0] target_o,
  output logic [4:0] count_o,
  output logic [1:0] state_o,
  output logic       win_o,
  output logic       lose_o,
  output logic [7:0] score_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShow   = 2'd1,
    StCount  = 2'd2,
    StResult = 2'd3
  } state_e;

  localparam logic [31:0] ShowLast   = 32'(TARGET_CYCLES - 1);
  localparam logic [31:0] ResultLast = 32'(RESULT_CYCLES - 1);
  localparam logic [31:0] LapsLast   = 32'(MAX_LAPS - 1);
  localparam logic [31:0] StepFull   = 32'(STEP_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] laps_q, laps_d;
  logic [4:0]  target_q, target_d;
  logic [4:0]  count_q, count_d;
  logic        next_q, next_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic [7:0]  score_q, score_d;
  logic [31:0] step_last;

`ifdef STOP_IT_SPEEDUP_EN
  logic [31:0] period_q, period_d;
  logic [1:0]  speed_shift;

  // Streaks beyond three wins keep the 1/8 period.
  assign speed_shift = (score_q > 8'd3) ? 2'd3 : score_q[1:0];
  assign step_last   = period_q - 32'd1;
`else
  assign step_last   = StepFull - 32'd1;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    laps_d   = laps_q;
    target_d = target_q;
    count_d  = count_q;
    next_d   = 1'b0;
    win_d    = win_q;
    lose_d   = lose_q;
    score_d  = score_q;
`ifdef STOP_IT_SPEEDUP_EN
    period_d = period_q;
`endif

    case (state_q)
      StIdle: begin
        if (go_i) begin
          target_d = rand_i;
          next_d   = 1'b1;
          state_d  = StShow;
          timer_d  = '0;
        end
      end

      StShow: begin
        if (timer_q == ShowLast) begin
          state_d = StCount;
          count_d = '0;
          timer_d = '0;
          laps_d  = '0;
`ifdef STOP_IT_SPEEDUP_EN
          period_d = StepFull >> speed_shift;
`endif
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StCount: begin
        // A stop press takes priority over a coincident step tick: judge the current value.
        if (stop_i) begin
          state_d = StResult;
          timer_d = '0;
          if (count_q == target_q) begin
            win_d   = 1'b1;
            score_d = (score_q == 8'hff) ? score_q : score_q + 8'd1;
          end else begin
            lose_d  = 1'b1;
            score_d = '0;
          end
        end else if (timer_q == step_last) begin
          timer_d = '0;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            if (laps_q == LapsLast) begin
              state_d = StResult;
              lose_d  = 1'b1;
              score_d = '0;
            end else begin
              laps_d = laps_q + 32'd1;
            end
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StResult: begin
        if (timer_q == ResultLast) begin
          state_d = StIdle;
          timer_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          count_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      laps_q   <= '0;
      target_q <= '0;
      count_q  <= '0;
      next_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      score_q  <= '0;
`ifdef STOP_IT_SPEEDUP_EN
      period_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      laps_q   <= laps_d;
      target_q <= target_d;
      count_q  <= count_d;
      next_q   <= next_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      score_q  <= score_d;
`ifdef STOP_IT_SPEEDUP_EN
      period_q <= period_d;
`endif
    end
  end

  assign next_o   = next_q;
  assign target_o = target_q;
  assign count_o  = count_q;
  assign state_o  = state_q;
  assign win_o    = win_q;
  assign lose_o   = lose_q;
  assign score_o  = score_q;

endmodule

// File: tb/tb_stop_it_game.sv
// Self-checking bench for stop_it_game with small timing parameters.
module tb_stop_it_game;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       go_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [4:0] rand_i = '0;
  logic       next_o;
  logic [4:0] target_o;
  logic [4:0] count_o;
  logic [1:0] state_o;
  logic       win_o;
  logic       lose_o;
  logic [7:0] score_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       win;
    logic       lose;
    logic [4:0] count;
    logic [7:0] score;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_score = '0;

  stop_it_game #(
    .STEP_CYCLES  (8),
    .TARGET_CYCLES(4),
    .RESULT_CYCLES(4),
    .MAX_LAPS     (2)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .go_i    (go_i),
    .stop_i  (stop_i),
    .rand_i  (rand_i),
    .next_o  (next_o),
    .target_o(target_o),
    .count_o (count_o),
    .state_o (state_o),
    .win_o   (win_o),
    .lose_o  (lose_o),
    .score_o (score_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int exp_period(input logic [7:0] s);
`ifdef STOP_IT_SPEEDUP_EN
    return 8 >> ((s > 8'd3) ? 3 : int'(s));
`else
    return 8;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Expected outcome of the round, recorded as the deciding stimulus is driven.
  task automatic push_exp(input logic w, input logic [4:0] c);
    exp_score = w ? ((exp_score == 8'hff) ? exp_score : exp_score + 8'd1) : 8'd0;
    sb_q.push_back({w, ~w, c, exp_score});
  endtask

  task automatic start_round(input logic [4:0] t);
    rand_i = t;
    go_i   = 1'b1;
    cyc(1);
    go_i   = 1'b0;
    rand_i = 5'd0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok, output int n);
    n = 0;
    while (state_o !== s && n < budget) begin
      cyc(1);
      n++;
    end
    ok = (state_o === s);
  endtask

  task automatic wait_count(input logic [4:0] v, input int budget, output bit ok, output int n);
    n = 0;
    while (count_o !== v && n < budget) begin
      cyc(1);
      n++;
    end
    ok = (count_o === v);
  endtask

  task automatic play_win(input logic [4:0] t);
    bit ok;
    int n;
    start_round(t);
    wait_state(2'd2, 20, ok, n);
    wait_count(t, 300, ok, n);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL play_win_reach got count=%0d want=%0d", count_o, t);
    end
    stop_i = 1'b1;
    push_exp(1'b1, t);
    cyc(1);
    stop_i = 1'b0;
    wait_state(2'd0, 20, ok, n);
  endtask

  // Result monitor: pops the scoreboard on each entry to RESULT and checks the hold phase.
  initial begin
    logic [1:0] prev_state;
    logic [6:0] held;
    int         res_len;
    exp_t       e;
    prev_state = 2'd0;
    held       = '0;
    res_len    = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        prev_state = 2'd0;
        res_len    = 0;
      end else begin
        if (win_o && lose_o) begin
          checks++;
          errors++;
          $display("FAIL win_lose_exclusive got win=%b lose=%b want not both", win_o, lose_o);
        end
        if (state_o == 2'd3 && prev_state != 2'd3) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected got win=%b lose=%b count=%0d want none",
                     win_o, lose_o, count_o);
          end else begin
            e = sb_q.pop_front();
            if ({win_o, lose_o, count_o, score_o} !== e) begin
              errors++;
              $display("FAIL result_entry got w=%b l=%b c=%0d s=%0d want w=%b l=%b c=%0d s=%0d",
                       win_o, lose_o, count_o, score_o, e.win, e.lose, e.count, e.score);
            end
          end
          held    = {win_o, lose_o, count_o};
          res_len = 1;
        end else if (state_o == 2'd3) begin
          res_len++;
          checks++;
          if ({win_o, lose_o, count_o} !== held) begin
            errors++;
            $display("FAIL result_hold got %b want %b", {win_o, lose_o, count_o}, held);
          end
        end else if (prev_state == 2'd3) begin
          checks++;
          if (res_len != 4 || win_o || lose_o || count_o != 5'd0) begin
            errors++;
            $display("FAIL result_exit got len=%0d w=%b l=%b c=%0d want len=4 w=0 l=0 c=0",
                     res_len, win_o, lose_o, count_o);
          end
        end
        prev_state = state_o;
      end
    end
  end

  task automatic test_reset();
    go_i   = 1'b1;
    rand_i = 5'd9;
    cyc(3);
    checks++;
    if ({next_o, target_o, count_o, state_o, win_o, lose_o, score_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got st=%0d tgt=%0d nxt=%b want all 0", state_o, target_o,
               next_o);
    end
    go_i = 1'b0;
    #4 rst_i = 1'b0;
    cyc(1);
    cyc(2);
    checks++;
    if (state_o !== 2'd0 || next_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_go_ignored got st=%0d nxt=%b want st=0 nxt=0", state_o, next_o);
    end
    start_round(5'd9);
    checks++;
    if (state_o !== 2'd1 || target_o !== 5'd9 || next_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_round got st=%0d tgt=%0d nxt=%b want st=1 tgt=9 nxt=1",
               state_o, target_o, next_o);
    end
    #4 rst_i = 1'b1;
    #1;
    checks++;
    if ({next_o, target_o, count_o, state_o, win_o, lose_o, score_o} !== '0) begin
      errors++;
      $display("FAIL reset_async got st=%0d tgt=%0d nxt=%b want all 0", state_o, target_o,
               next_o);
    end
    #2;
    cyc(1);
    #4 rst_i = 1'b0;
    cyc(1);
  endtask

  task automatic test_win();
    int shows, nexts, n;
    bit ok;
    start_round(5'd5);
    checks++;
    if (target_o !== 5'd5) begin
      errors++;
      $display("FAIL win_target got %0d want 5", target_o);
    end
    shows = 0;
    nexts = 0;
    while (state_o === 2'd1 && shows < 20) begin
      shows++;
      if (next_o) nexts++;
      cyc(1);
    end
    checks++;
    if (shows != 4 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL win_show_len got len=%0d st=%0d want len=4 st=2", shows, state_o);
    end
    checks++;
    if (nexts != 1) begin
      errors++;
      $display("FAIL win_next_pulse got %0d cycles want 1", nexts);
    end
    checks++;
    if (count_o !== 5'd0) begin
      errors++;
      $display("FAIL win_count_entry got %0d want 0", count_o);
    end
    wait_count(5'd5, 100, ok, n);
    checks++;
    if (!ok || n != 40) begin
      errors++;
      $display("FAIL win_count_time got ok=%b cycles=%0d want ok=1 cycles=40", ok, n);
    end
    stop_i = 1'b1;
    push_exp(1'b1, 5'd5);
    cyc(1);
    stop_i = 1'b0;
    checks++;
    if (state_o !== 2'd3) begin
      errors++;
      $display("FAIL win_result_state got %0d want 3", state_o);
    end
    wait_state(2'd0, 20, ok, n);
    checks++;
    if (!ok || score_o !== 8'd1) begin
      errors++;
      $display("FAIL win_score got ok=%b score=%0d want ok=1 score=1", ok, score_o);
    end
  endtask

  task automatic test_loss();
    int n;
    bit ok;
    start_round(5'd5);
    wait_state(2'd2, 20, ok, n);
    wait_count(5'd4, 100, ok, n);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loss_reach got count=%0d want 4", count_o);
    end
    stop_i = 1'b1;
    push_exp(1'b0, 5'd4);
    cyc(1);
    stop_i = 1'b0;
    wait_state(2'd0, 20, ok, n);
    checks++;
    if (!ok || score_o !== 8'd0 || target_o !== 5'd5) begin
      errors++;
      $display("FAIL loss_after got ok=%b score=%0d tgt=%0d want ok=1 score=0 tgt=5",
               ok, score_o, target_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    start_round(5'd7);
    wait_state(2'd2, 20, ok, n);
    push_exp(1'b0, 5'd0);
    wait_state(2'd3, 600, ok, n);
    checks++;
    if (!ok || n != 512) begin
      errors++;
      $display("FAIL timeout_len got ok=%b cycles=%0d want ok=1 cycles=512", ok, n);
    end
    wait_state(2'd0, 20, ok, n);
  endtask

  task automatic test_back_to_back();
    int n, nexts;
    bit ok;
    start_round(5'd5);
    wait_state(2'd2, 20, ok, n);
    wait_count(5'd5, 100, ok, n);
    cyc(7);
    checks++;
    if (count_o !== 5'd5) begin
      errors++;
      $display("FAIL coincide_pre got count=%0d want 5", count_o);
    end
    stop_i = 1'b1;
    push_exp(1'b1, 5'd5);
    cyc(1);
    stop_i = 1'b0;
    go_i   = 1'b1;
    stop_i = 1'b1;
    cyc(1);
    go_i   = 1'b0;
    stop_i = 1'b0;
    checks++;
    if (state_o !== 2'd3 || win_o !== 1'b1 || count_o !== 5'd5) begin
      errors++;
      $display("FAIL coincide_result got st=%0d win=%b count=%0d want st=3 win=1 count=5",
               state_o, win_o, count_o);
    end
    nexts = 0;
    for (int i = 0; i < 6; i++) begin
      if (next_o) nexts++;
      cyc(1);
    end
    checks++;
    if (nexts != 0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL result_ignores got next=%0d st=%0d want next=0 st=0", nexts, state_o);
    end
  endtask

  task automatic test_step_rate();
    int n, want;
    bit ok;
    play_win(5'd3);
    start_round(5'd2);
    wait_state(2'd2, 20, ok, n);
    want = exp_period(exp_score);
    wait_count(5'd1, 20, ok, n);
    checks++;
    if (n != want) begin
      errors++;
      $display("FAIL step_rate_score2 got %0d cycles want %0d", n, want);
    end
    wait_count(5'd2, 20, ok, n);
    stop_i = 1'b1;
    push_exp(1'b1, 5'd2);
    cyc(1);
    stop_i = 1'b0;
    wait_state(2'd0, 20, ok, n);
    play_win(5'd1);
    play_win(5'd1);
    start_round(5'd3);
    wait_state(2'd2, 20, ok, n);
    want = exp_period(exp_score);
    wait_count(5'd1, 20, ok, n);
    checks++;
    if (n != want) begin
      errors++;
      $display("FAIL step_rate_score5 got %0d cycles want %0d", n, want);
    end
    wait_count(5'd3, 40, ok, n);
    stop_i = 1'b1;
    push_exp(1'b1, 5'd3);
    cyc(1);
    stop_i = 1'b0;
    wait_state(2'd0, 20, ok, n);
    checks++;
    if (score_o !== exp_score) begin
      errors++;
      $display("FAIL step_rate_score got %0d want %0d", score_o, exp_score);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_win();
    test_loss();
    test_timeout();
    test_back_to_back();
    test_step_rate();
    cyc(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
